song_sequencer: RTL and testbench

- Autoplay scheduler for the buzzer datapath.
- Walks the song memory entry by entry, fetching each entry over a req/valid handshake.
- Drives the tone generator with note and octave for a duration given by the entry's length code, then inserts an articulation gap.
- Exposes play position and status to the tube display and mode logic.

---
 rtl/song_sequencer.sv | 169 ++++++++++++++++
 tb/tb_song_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Autoplay scheduler: fetches song entries, times each note and its articulation gap.
// Define SONG_REPEAT_EN to loop the song from address 0 until stop.
module song_sequencer #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned LEN_W    = 3,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned UNIT_MS  = 125,
    parameter int unsigned GAP_MS   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [NOTE_W-1:0] mem_note,
    input  logic [1:0]        mem_oct,
    input  logic [LEN_W-1:0]  mem_len,
    output logic              tone_en,
    output logic [NOTE_W-1:0] tone_note,
    output logic [1:0]        tone_oct,
    output logic              playing,
    output logic [ADDR_W-1:0] song_pos,
    output logic              done
);

    localparam int unsigned DurMax = (1 << LEN_W) * UNIT_MS;
    localparam int unsigned CntMax = (DurMax > GAP_MS) ? DurMax : GAP_MS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPlay,
        StGap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PreW-1:0]   pre_q, pre_d;
    // Shared down-counter: note duration in PLAY, gap length in GAP.
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [1:0]        oct_q, oct_d;
    logic              tick;
    logic              last_cnt;
    logic              advance;

    assign tick     = (pre_q == PreW'(TICK_DIV - 1));
    assign last_cnt = (cnt_q == CntW'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        oct_d   = oct_q;
        advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (mem_valid) begin
                    if (&mem_note) begin
                        state_d = StDone;
                    end else begin
                        note_d  = mem_note;
                        oct_d   = mem_oct;
                        cnt_d   = CntW'((32'(mem_len) + 32'd1) * UNIT_MS);
                        pre_d   = '0;
                        state_d = StPlay;
                    end
                end
            end
            StPlay: begin
                if (!pause) begin
                    if (tick) begin
                        pre_d = '0;
                        cnt_d = cnt_q - CntW'(1);
                        if (last_cnt) begin
                            if (GAP_MS != 0) begin
                                cnt_d   = CntW'(GAP_MS);
                                state_d = StGap;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PreW'(1);
                    end
                end
            end
            StGap: begin
                if (!pause) begin
                    if (tick) begin
                        pre_d = '0;
                        cnt_d = cnt_q - CntW'(1);
                        if (last_cnt) begin
                            advance = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + PreW'(1);
                    end
                end
            end
            StDone: begin
`ifdef SONG_REPEAT_EN
                addr_d  = '0;
                state_d = StFetch;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        // The last address ends the song rather than wrapping back to 0.
        if (advance) begin
            if (&addr_q) begin
                state_d = StDone;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = StFetch;
            end
        end

        if (stop) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
        end
    end

    assign mem_req   = (state_q == StFetch);
    assign mem_addr  = addr_q;
    assign song_pos  = addr_q;
    assign tone_en   = (state_q == StPlay) && (note_q != '0) && !pause;
    assign tone_note = note_q;
    assign tone_oct  = oct_q;
    assign playing   = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: directed songs, expected events queued, monitor compares.
module tb_song_sequencer;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NOTE_W = 4;
    localparam int unsigned LEN_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid = 1'b0;
    logic [NOTE_W-1:0] mem_note = '0;
    logic [1:0]        mem_oct = '0;
    logic [LEN_W-1:0]  mem_len = '0;
    logic              tone_en;
    logic [NOTE_W-1:0] tone_note;
    logic [1:0]        tone_oct;
    logic              playing;
    logic [ADDR_W-1:0] song_pos;
    logic              done;

    song_sequencer #(
        .ADDR_W  (ADDR_W),
        .NOTE_W  (NOTE_W),
        .LEN_W   (LEN_W),
        .TICK_DIV(4),
        .UNIT_MS (2),
        .GAP_MS  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_valid(mem_valid),
        .mem_note (mem_note),
        .mem_oct  (mem_oct),
        .mem_len  (mem_len),
        .tone_en  (tone_en),
        .tone_note(tone_note),
        .tone_oct (tone_oct),
        .playing  (playing),
        .song_pos (song_pos),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef enum int {EvFetch, EvTone, EvDone, EvIdle} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int unsigned a;
        int unsigned b;
        int unsigned t;
    } ev_t;
    typedef struct {
        logic [NOTE_W-1:0] note;
        logic [1:0]        oct;
        logic [LEN_W-1:0]  len;
    } entry_t;

    ev_t         exp_q[$];
    entry_t      mem[64];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    bit          inject = 1'b0;
    int unsigned lat = 0;
    bit          req_prev = 1'b0;
    bit          play_prev = 1'b0;
    int unsigned run = 0;
    int unsigned run_nb = 0;

    function automatic void chk(string name, int unsigned got, int unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endfunction

    // Event times are relative to the cycle in which start is first seen.
    function automatic void exp_ev(ev_kind_e k, int unsigned a, int unsigned b, int unsigned rel);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        e.t    = t0 + rel;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(ev_kind_e k, int unsigned a, int unsigned b, int unsigned t);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got %s a=%0d b=%0d rel %0d, expected none",
                     k.name(), a, b, t - t0);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.a == a && e.b == b && e.t == t) n_pass++;
            else $display("FAIL event: got %s a=%0d b=%0d rel %0d, expected %s a=%0d b=%0d rel %0d",
                          k.name(), a, b, t - t0, e.kind.name(), e.a, e.b, e.t - t0);
        end
    endfunction

    // Monitor: turns DUT output activity into events and checks them against the queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req && !req_prev) observe(EvFetch, 32'(mem_addr), 32'(song_pos), cyc);
            if (tone_en) begin
                run++;
                run_nb = 32'({tone_note, tone_oct});
            end else if (run != 0) begin
                observe(EvTone, run, run_nb, cyc);
                run = 0;
            end
            if (done) observe(EvDone, 0, 0, cyc);
            if (!playing && play_prev) observe(EvIdle, 0, 0, cyc);
            req_prev  = mem_req;
            play_prev = playing;
        end
    end

    // Memory responder: mem_valid two cycles after mem_req is first seen, for one cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mem_valid = 1'b0;
                lat = 0;
            end else if (mem_valid) begin
                mem_valid = 1'b0;
            end else if (inject) begin
                inject    = 1'b0;
                mem_note  = mem[0].note;
                mem_oct   = mem[0].oct;
                mem_len   = mem[0].len;
                mem_valid = 1'b1;
            end else if (mem_req) begin
                lat++;
                if (lat == 2) begin
                    lat       = 0;
                    mem_note  = mem[mem_addr].note;
                    mem_oct   = mem[mem_addr].oct;
                    mem_len   = mem[mem_addr].len;
                    mem_valid = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        t0 = cyc + 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic drain(string name, int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) step(1);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        step(6);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_tone_en"}, 32'(tone_en), 0);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_playing"}, 32'(playing), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_song_pos"}, 32'(song_pos), 0);
        chk({tag, "_tone_note"}, 32'(tone_note), 0);
        chk({tag, "_tone_oct"}, 32'(tone_oct), 0);
    endtask

    initial begin
        step(3);
        check_zero("reset");
        rst_n = 1'b1;
        step(2);

`ifdef SONG_REPEAT_EN
        mem[0] = '{note: 4'd3, oct: 2'd2, len: 3'd0};
        mem[1] = '{note: 4'd4, oct: 2'd0, len: 3'd0};
        mem[2] = '{note: 4'd15, oct: 2'd0, len: 3'd0};
        mark();
        for (int p = 0; p < 3; p++) begin
            exp_ev(EvFetch, 0, 0, 1 + 31 * p);
            exp_ev(EvTone, 8, 14, 11 + 31 * p);
            exp_ev(EvFetch, 1, 1, 15 + 31 * p);
            exp_ev(EvTone, 8, 16, 25 + 31 * p);
            exp_ev(EvFetch, 2, 2, 29 + 31 * p);
            exp_ev(EvDone, 0, 0, 31 + 31 * p);
        end
        exp_ev(EvFetch, 0, 0, 94);
        exp_ev(EvIdle, 0, 0, 95);
        pulse_start();
        step(93);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("repeat_stop_playing", 32'(playing), 0);
        drain("repeat_drain", 200);
`else
        // Single note then END.
        mem[0] = '{note: 4'd5, oct: 2'd1, len: 3'd0};
        mem[1] = '{note: 4'd15, oct: 2'd0, len: 3'd0};
        mark();
        exp_ev(EvFetch, 0, 0, 1);
        exp_ev(EvTone, 8, 21, 11);
        exp_ev(EvFetch, 1, 1, 15);
        exp_ev(EvDone, 0, 0, 17);
        exp_ev(EvIdle, 0, 0, 18);
        pulse_start();
        drain("note_drain", 100);
        chk("note_end_playing", 32'(playing), 0);

        // Rest entry: silent for 16 cycles.
        mem[0] = '{note: 4'd0, oct: 2'd0, len: 3'd1};
        mark();
        exp_ev(EvFetch, 0, 0, 1);
        exp_ev(EvFetch, 1, 1, 23);
        exp_ev(EvDone, 0, 0, 25);
        exp_ev(EvIdle, 0, 0, 26);
        pulse_start();
        drain("rest_drain", 100);

        // Pause for 10 cycles after 3 tone cycles.
        mem[0] = '{note: 4'd5, oct: 2'd1, len: 3'd0};
        mark();
        exp_ev(EvFetch, 0, 0, 1);
        exp_ev(EvTone, 3, 21, 6);
        exp_ev(EvTone, 5, 21, 21);
        exp_ev(EvFetch, 1, 1, 25);
        exp_ev(EvDone, 0, 0, 27);
        exp_ev(EvIdle, 0, 0, 28);
        pulse_start();
        step(5);
        pause = 1'b1;
        step(5);
        chk("pause_tone_en", 32'(tone_en), 0);
        chk("pause_playing", 32'(playing), 1);
        step(5);
        pause = 1'b0;
        drain("pause_drain", 100);

        // Stop together with start during PLAY, then a stray mem_valid.
        mark();
        exp_ev(EvFetch, 0, 0, 1);
        exp_ev(EvTone, 2, 21, 5);
        exp_ev(EvIdle, 0, 0, 5);
        pulse_start();
        step(3);
        stop  = 1'b1;
        start = 1'b1;
        step(1);
        stop  = 1'b0;
        start = 1'b0;
        chk("stop_tone_en", 32'(tone_en), 0);
        chk("stop_playing", 32'(playing), 0);
        chk("stop_mem_req", 32'(mem_req), 0);
        inject = 1'b1;
        step(4);
        chk("late_valid_playing", 32'(playing), 0);
        chk("late_valid_mem_req", 32'(mem_req), 0);
        drain("stop_drain", 50);

        // Reset in the middle of a note.
        mark();
        exp_ev(EvFetch, 0, 0, 1);
        exp_ev(EvTone, 2, 21, 5);
        exp_ev(EvIdle, 0, 0, 5);
        pulse_start();
        step(3);
        rst_n = 1'b0;
        step(1);
        check_zero("midreset");
        rst_n = 1'b1;
        drain("midreset_drain", 50);

        // 64 entries without an END marker.
        for (int k = 0; k < 64; k++) mem[k] = '{note: 4'd1, oct: 2'd0, len: 3'd0};
        mark();
        for (int k = 0; k < 64; k++) begin
            exp_ev(EvFetch, k, k, 1 + 14 * k);
            exp_ev(EvTone, 8, 4, 11 + 14 * k);
        end
        exp_ev(EvDone, 0, 0, 897);
        exp_ev(EvIdle, 0, 0, 898);
        pulse_start();
        drain("full_drain", 1200);
        chk("full_end_playing", 32'(playing), 0);
        chk("full_end_mem_req", 32'(mem_req), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
